// File: rtl/moving_average_param.sv
// Boxcar moving average over 2^LOG2_DEPTH strobed samples using a circular buffer and running sum.
// Optional build macro MOVING_AVERAGE_ROUND_EN selects round-half-up output instead of truncation.
module moving_average_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  win_full,
  output logic [LOG2_DEPTH:0]   sample_cnt
);

  localparam int unsigned N     = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] N_CNT = (LOG2_DEPTH+1)'(N);

  logic [DATA_W-1:0]     sample_buf [N];
  logic [SUM_W-1:0]      sum_q;
  logic [LOG2_DEPTH-1:0] wptr_q;

  logic [DATA_W-1:0]     old_sample;
  logic [SUM_W-1:0]      base_sum;
  logic [LOG2_DEPTH:0]   base_cnt;
  logic [LOG2_DEPTH-1:0] wsel;
  logic [SUM_W-1:0]      sum_d;
  logic [LOG2_DEPTH-1:0] wptr_d;
  logic [LOG2_DEPTH:0]   cnt_d;
  logic [DATA_W-1:0]     out_d;
  logic [SUM_W-1:0]      sum_acc;
`ifdef MOVING_AVERAGE_ROUND_EN
  localparam logic [SUM_W:0] HALF = (SUM_W+1)'(N / 2);
  logic [SUM_W:0]        sum_rnd;
`endif

  // Flush is folded in as a zeroed baseline so a coincident sample starts a fresh window.
  always_comb begin
    old_sample = flush ? '0 : sample_buf[wptr_q];
    base_sum   = flush ? '0 : sum_q;
    base_cnt   = flush ? '0 : sample_cnt;
    wsel       = flush ? '0 : wptr_q;
    sum_acc    = base_sum + SUM_W'(in_data) - SUM_W'(old_sample);
`ifdef MOVING_AVERAGE_ROUND_EN
    sum_rnd    = {1'b0, sum_acc} + HALF;
`endif
    sum_d  = base_sum;
    wptr_d = wsel;
    cnt_d  = base_cnt;
    out_d  = flush ? '0 : out_data;
    if (in_valid) begin
      sum_d  = sum_acc;
      wptr_d = wsel + 1'b1;
      cnt_d  = (base_cnt == N_CNT) ? base_cnt : base_cnt + 1'b1;
`ifdef MOVING_AVERAGE_ROUND_EN
      out_d  = DATA_W'(sum_rnd >> LOG2_DEPTH);
`else
      out_d  = DATA_W'(sum_acc >> LOG2_DEPTH);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) sample_buf[i] <= '0;
      sum_q      <= '0;
      wptr_q     <= '0;
      sample_cnt <= '0;
      win_full   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      out_valid <= in_valid;
      if (flush) begin
        for (int unsigned i = 0; i < N; i++) sample_buf[i] <= '0;
      end
      if (in_valid) sample_buf[wsel] <= in_data;
      if (flush || in_valid) begin
        sum_q      <= sum_d;
        wptr_q     <= wptr_d;
        sample_cnt <= cnt_d;
        win_full   <= (cnt_d == N_CNT);
        out_data   <= out_d;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_param.sv
// Scoreboard bench for moving_average_param (DATA_W=8, LOG2_DEPTH=2) with directed vectors.
module tb_moving_average_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       win_full;
  logic [2:0] sample_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0] expq[$];

  moving_average_param #(.DATA_W(8), .LOG2_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .win_full(win_full), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got out_data %0d, expected no output", out_data);
      end else begin
        chk("out_data", {24'd0, out_data}, {24'd0, expq.pop_front()});
      end
    end
  end

  // Inputs change at a falling edge and are consumed by the following rising edge.
  task automatic step(input logic v, input logic f, input logic [7:0] d, input int exp);
    in_valid = v;
    flush    = f;
    in_data  = d;
    if (v) expq.push_back(8'(exp));
    @(negedge clk);
  endtask

  int seq2 [8] = '{1, 2, 3, 4, 0, 1, 2, 3};
`ifdef MOVING_AVERAGE_ROUND_EN
  int exp2 [8] = '{0, 1, 2, 3, 2, 2, 2, 2};
  int exp4 [4] = '{64, 128, 191, 255};
`else
  int exp2 [8] = '{0, 0, 1, 2, 2, 2, 1, 1};
  int exp4 [4] = '{63, 127, 191, 255};
`endif

  initial begin
    // 1: reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_data",   {24'd0, out_data},   0);
    chk("reset_out_valid",  {31'd0, out_valid},  0);
    chk("reset_win_full",   {31'd0, win_full},   0);
    chk("reset_sample_cnt", {29'd0, sample_cnt}, 0);

    // 2/3: one-cycle strobes, idle cycles carry garbage data
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(seq2[i]), exp2[i]);
      chk("seq_sample_cnt", {29'd0, sample_cnt}, (i < 3) ? i + 1 : 4);
      chk("seq_win_full",   {31'd0, win_full},   (i >= 3) ? 1 : 0);
      step(1'b0, 1'b0, 8'hAA, 0);
    end
    chk("idle_hold_out_data", {24'd0, out_data}, exp2[7]);

    // 4: flush without sample, then full-scale back-to-back
    step(1'b0, 1'b1, 8'h55, 0);
    chk("flush_out_data",   {24'd0, out_data},   0);
    chk("flush_sample_cnt", {29'd0, sample_cnt}, 0);
    chk("flush_win_full",   {31'd0, win_full},   0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'hFF, exp4[i]);
      chk("b2b_out_valid", {31'd0, out_valid}, 1);
    end
    step(1'b0, 1'b0, 8'h00, 0);
    chk("b2b_win_full", {31'd0, win_full}, 1);

    // 5: full window of 4s, then flush with a coincident sample
    step(1'b0, 1'b1, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'd4, i + 1);
    chk("fours_win_full", {31'd0, win_full}, 1);
    step(1'b1, 1'b1, 8'd8, 2);
    chk("flushload_sample_cnt", {29'd0, sample_cnt}, 1);
    chk("flushload_win_full",   {31'd0, win_full},   0);
    chk("flushload_out_valid",  {31'd0, out_valid},  1);
    step(1'b0, 1'b0, 8'h00, 0);
    step(1'b1, 1'b0, 8'd8, 4);
    chk("after_flush_sample_cnt", {29'd0, sample_cnt}, 2);
    step(1'b0, 1'b0, 8'h00, 0);

    // 6: asynchronous reset with a strobe in flight
    step(1'b0, 1'b1, 8'h00, 0);
    step(1'b1, 1'b0, 8'd100, 25);
    step(1'b1, 1'b0, 8'd100, 50);
    in_data = 8'd200;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_data",   {24'd0, out_data},   0);
    chk("async_out_valid",  {31'd0, out_valid},  0);
    chk("async_win_full",   {31'd0, win_full},   0);
    chk("async_sample_cnt", {29'd0, sample_cnt}, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 8'd4, 1);
    chk("post_reset_sample_cnt", {29'd0, sample_cnt}, 1);
    step(1'b0, 1'b0, 8'h00, 0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/moving_average_param.md
Name: moving_average_param

Overview:
Parametrised successor to the single-channel 8-bit moving averager. It computes a boxcar mean over a window of 2^LOG2_DEPTH strobed samples using a circular sample buffer and a running sum. It adds a configurable width and window depth, a synchronous flush, a window-full status flag and a sample counter. It sits between the pad-level input sampler (data plus strobe) and the output pins.

Parameters:
DATA_W, 8, sample and output width in bits (unsigned)
LOG2_DEPTH, 2, log2 of window length; window N = 2^LOG2_DEPTH, legal range 1..6

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  sample strobe; every cycle it is high consumes one sample
in_data  input  DATA_W  unsigned sample, qualified by in_valid
flush  input  1  synchronous clear of buffer, sum and counters
out_valid  output  1  one-cycle pulse, out_data updated this cycle
out_data  output  DATA_W  current window mean, held between updates
win_full  output  1  high once N samples have been accepted since reset/flush
sample_cnt  output  LOG2_DEPTH+1  accepted samples since reset/flush, saturates at N

Behaviour:
- Reset (rst_n=0, asynchronous): buffer entries=0, sum=0, write pointer=0, sample_cnt=0, win_full=0, out_valid=0, out_data=0. Deassertion is taken synchronously by the next rising edge.
- Running sum width is DATA_W+LOG2_DEPTH bits and can never overflow: max sum = N*(2^DATA_W-1).
- Accept (in_valid=1, flush=0): on that edge:
  - sum_next = sum + in_data - buf[wptr]
  - buf[wptr] = in_data
  - wptr = (wptr+1) mod N, wrapping naturally at N-1 -> 0
  - sample_cnt increments, saturating at N
- Output: on the same edge, out_data = sum_next >> LOG2_DEPTH (truncating) and out_valid=1 for exactly one cycle. Latency is 1 clock from strobe edge to result.
- Warm-up: before N samples, empty slots count as 0 and the divisor is always N. No partial-window division.
- win_full = (sample_cnt == N); registered, updated on the same edge as sample_cnt.
- in_valid held high for k cycles = k samples. Back-to-back samples give one out_valid per cycle, full throughput.
- in_valid=0: all state holds; out_valid=0; out_data holds its last value.
- Flush (flush=1) on edge:
  - buffer, sum, wptr, sample_cnt, win_full and out_data go to 0.
  - If in_valid=1 simultaneously, flush wins for the clear, then the sample is loaded as the first sample of a fresh window: buf[0]=in_data, sum=in_data, wptr=1, sample_cnt=1, out_data=in_data>>LOG2_DEPTH, out_valid=1.
  - If in_valid=0, out_valid=0.
- Reset mid-stream discards all history immediately, including a strobe in flight.
- in_data while in_valid=0 is don't-care and must not affect state.

Optional Feature:
MOVING_AVERAGE_ROUND_EN
- Defined: out_data = (sum_next + 2^(LOG2_DEPTH-1)) >> LOG2_DEPTH (round half up). The adder is DATA_W+LOG2_DEPTH+1 bits wide. The result is provably at most 2^DATA_W-1, so no saturation logic is needed.
- Undefined: plain truncation as above; no rounding adder present.
- Sum, buffer, flag and counter behaviour are identical either way.

Test Plan:
1. Reset then idle, defaults (DATA_W=8, LOG2_DEPTH=2) -> out_data=0, out_valid=0, win_full=0, sample_cnt=0.
2. One-cycle strobes 1,2,3,4,0,1,2,3, truncating build:
   - out_data per sample 0,0,1,2,2,2,1,1
   - out_valid one pulse each
   - win_full rises with the 4th sample; sample_cnt stays at 4.
3. Same sequence with MOVING_AVERAGE_ROUND_EN defined -> out_data 0,1,2,3,2,2,2,2.
4. Four back-to-back strobes of 0xFF (in_valid high 4 cycles) -> out_data 63,127,191,255, with out_valid high 4 consecutive cycles. Both builds: full scale gives no overflow, and the last value is 255.
5. After a full window of 4s, assert flush with in_valid=1, in_data=8 -> sample_cnt=1, win_full=0, out_data=2, out_valid=1. The next sample 8 gives out_data=4.
6. Assert rst_n=0 asynchronously mid-strobe between edges -> all outputs 0 immediately. After release, sample 4 gives out_data=1 (no stale history).
